// File: rtl/brick_game_pkg.sv
// Shared types and constants for the brick-breaker game path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package brick_game_pkg;

  typedef enum logic [2:0] {
    SERVE   = 3'd0,
    PLAY    = 3'd1,
    RESPAWN = 3'd2,
    WON     = 3'd3,
    LOST    = 3'd4
  } game_state_t;

  localparam int NUM_BRICKS_DEFAULT = 9;

  // 24-bit RGB colours consumed by color_mapper.
  localparam logic [23:0] BRICK_COLOR  = 24'hE0_40_20;
  localparam logic [23:0] PADDLE_COLOR = 24'h20_A0_E0;
  localparam logic [23:0] BALL_COLOR   = 24'hFF_FF_FF;
  localparam logic [23:0] BG_COLOR     = 24'h10_10_30;
  localparam logic [23:0] WIN_COLOR    = 24'h20_C0_40;
  localparam logic [23:0] LOSE_COLOR   = 24'hC0_20_20;

  // Unsigned 16-bit add that clamps at all-ones instead of wrapping.
  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// Rising-edge detector for a level input (e.g. a decoded key).
// Latency: combinational pulse in the cycle the level first reads high.
// Backpressure: none; history resets to 1 so a level held through reset gives no pulse.
//
// Ports: clk, rst_n (async active-low), sig (level in), rise (pulse out).
module edge_detect_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic sig,
  output logic rise
);

  logic sig_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sig_d <= 1'b1;
    end else begin
      sig_d <= sig;
    end
  end

  assign rise = sig & ~sig_d;

endmodule

// File: rtl/brick_game_ctrl.sv
// Per-frame game sequencer: bricks, lives, score, serve/play/respawn/win/lose.
// Latency: registered outputs update one frame after the triggering input.
// Backpressure: none; every hit_valid cycle is acked on the next frame.
//
// Ports: frame_clk, Reset (async active-low), start (key level),
//        hit_valid/hit_idx -> hit_ack, ball_missed, brick_exists, ball_hold,
//        ball_launch, lives, score, did_win_game, did_lose_game.
module brick_game_ctrl
  import brick_game_pkg::*;
#(
  parameter int NUM_BRICKS       = NUM_BRICKS_DEFAULT,
  parameter int START_LIVES      = 3,
  parameter int POINTS_PER_BRICK = 10,
  parameter int RESPAWN_FRAMES   = 60
) (
  input  logic                  frame_clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic                  hit_valid,
  input  logic [3:0]            hit_idx,
  output logic                  hit_ack,
  input  logic                  ball_missed,
  output logic [NUM_BRICKS-1:0] brick_exists,
  output logic                  ball_hold,
  output logic                  ball_launch,
  output logic [2:0]            lives,
  output logic [15:0]           score,
  output logic                  did_win_game,
  output logic                  did_lose_game
);

  localparam int CNT_W = (RESPAWN_FRAMES > 1) ? $clog2(RESPAWN_FRAMES) : 1;
  localparam logic [CNT_W-1:0]      CNT_LAST   = CNT_W'(RESPAWN_FRAMES - 1);
  localparam logic [NUM_BRICKS-1:0] ALL_BRICKS = '1;
  localparam logic [NUM_BRICKS-1:0] ONE_BRICK  = NUM_BRICKS'(1);
  localparam logic [2:0]            LIVES_INIT = 3'(START_LIVES);
  localparam logic [15:0]           POINTS     = 16'(POINTS_PER_BRICK);

  game_state_t           state, state_nxt;
  logic [NUM_BRICKS-1:0] bricks_nxt;
  logic [2:0]            lives_nxt;
  logic [15:0]           score_nxt;
  logic [CNT_W-1:0]      respawn_cnt, cnt_nxt;
  logic                  launch_nxt;
  logic                  start_rise;

  logic                  hit_in_range;
  logic [NUM_BRICKS-1:0] hit_mask;
  logic                  hit_effective;
  logic [NUM_BRICKS-1:0] bricks_after_hit;

  edge_detect_rise u_start_edge (
    .clk   (frame_clk),
    .rst_n (Reset),
    .sig   (start),
    .rise  (start_rise)
  );

  // Out-of-range indices produce no effect; the mask is also gated so a
  // shift past the vector width can never alias onto a real brick.
  assign hit_in_range     = 32'(hit_idx) < 32'(NUM_BRICKS);
  assign hit_mask         = hit_in_range ? (ONE_BRICK << hit_idx) : '0;
  assign hit_effective    = hit_valid && |(brick_exists & hit_mask);
  assign bricks_after_hit = brick_exists & ~hit_mask;

  always_ff @(posedge frame_clk or negedge Reset) begin
    if (!Reset) begin
      state        <= SERVE;
      brick_exists <= ALL_BRICKS;
      lives        <= LIVES_INIT;
      score        <= 16'd0;
      respawn_cnt  <= '0;
      hit_ack      <= 1'b0;
      ball_launch  <= 1'b0;
    end else begin
      state        <= state_nxt;
      brick_exists <= bricks_nxt;
      lives        <= lives_nxt;
      score        <= score_nxt;
      respawn_cnt  <= cnt_nxt;
      // Every presented hit is consumed, whatever state we are in.
      hit_ack      <= hit_valid;
      ball_launch  <= launch_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    bricks_nxt = brick_exists;
    lives_nxt  = lives;
    score_nxt  = score;
    cnt_nxt    = respawn_cnt;
    launch_nxt = 1'b0;

    unique case (state)
      SERVE: begin
        if (start_rise) begin
          launch_nxt = 1'b1;
          state_nxt  = PLAY;
        end
      end

      PLAY: begin
        if (hit_effective) begin
          bricks_nxt = bricks_after_hit;
          score_nxt  = sat_add16(score, POINTS);
        end
        // Clearing the last brick wins even if the ball was also missed.
        if (hit_effective && (bricks_after_hit == '0)) begin
          state_nxt = WON;
        end else if (ball_missed) begin
          if (lives > 3'd1) begin
            lives_nxt = lives - 3'd1;
            cnt_nxt   = '0;
            state_nxt = RESPAWN;
          end else begin
            lives_nxt = 3'd0;
            state_nxt = LOST;
          end
        end
      end

      RESPAWN: begin
        cnt_nxt = respawn_cnt + 1'b1;
        if (respawn_cnt == CNT_LAST) begin
          state_nxt = SERVE;
        end
      end

      WON, LOST: begin
        // Restart parks the ball; a fresh key press is needed to serve.
        if (start_rise) begin
          bricks_nxt = ALL_BRICKS;
          lives_nxt  = LIVES_INIT;
          score_nxt  = 16'd0;
          state_nxt  = SERVE;
        end
      end

      default: begin
        state_nxt = SERVE;
      end
    endcase
  end

  assign ball_hold     = (state == SERVE) || (state == RESPAWN);
  assign did_win_game  = (state == WON);
  assign did_lose_game = (state == LOST);

endmodule

// File: doc/brick_game_ctrl.md
Name: brick_game_ctrl

Overview:
Per-frame game sequencer for the brick-breaker display path. It owns brick existence, lives and score, and runs the serve/play/respawn/game-over sequence. It accepts brick-hit and ball-missed events from the ball/collision logic and drives brick_exists, did_win_game and did_lose_game into color_mapper, plus the ball serve controls.

Parameters:
NUM_BRICKS, 9, number of bricks; bit i of brick_exists corresponds to brick i.
START_LIVES, 3, lives loaded on reset and on restart; range 1..7.
POINTS_PER_BRICK, 10, score increment per valid hit.
RESPAWN_FRAMES, 60, frames spent in RESPAWN after a miss before returning to SERVE.

Ports:
frame_clk  in  1  clock; one rising edge per video frame
Reset  in  1  asynchronous, active-low reset
start  in  1  level from the keyboard decode; only its rising edge is used
hit_valid  in  1  collision logic presents a brick hit
hit_idx  in  4  index of the hit brick
hit_ack  out  1  one-cycle pulse; the hit presented this cycle has been consumed
ball_missed  in  1  one-cycle pulse; ball passed below the paddle
brick_exists  out  9  1 = brick i still standing
ball_hold  out  1  ball is parked on the paddle and follows it
ball_launch  out  1  one-cycle pulse; collision logic releases the ball with its initial velocity
lives  out  3  remaining lives
score  out  16  accumulated score
did_win_game  out  1  high while in WON
did_lose_game  out  1  high while in LOST

Behaviour:
- Reset asserted (Reset=0), asynchronously:
  - state=SERVE, brick_exists=all ones, lives=START_LIVES, score=0, respawn counter=0.
  - hit_ack=0, ball_launch=0, start history register=1. The history value of 1 means a key held through reset does not launch the ball.
  - Derived outputs at reset: ball_hold=1, did_win_game=0, did_lose_game=0.
- Registered outputs: brick_exists, lives, score, hit_ack and ball_launch. All of them update on the edge after the triggering input is sampled (1-frame latency).
- ball_hold, did_win_game and did_lose_game are decoded combinationally from state only.
- start_rise = start & ~start_d, where start_d is the start value registered on the previous frame.
- States:
  - SERVE: ball_hold=1. On start_rise: pulse ball_launch and go to PLAY. Hits and misses are ignored here, but hit_ack is still pulsed for any hit_valid.
  - PLAY: handles hits and misses.
    - Hit: hit_valid asserted → hit_ack=1 on the next edge, regardless of validity.
    - The hit is effective only if hit_idx<NUM_BRICKS and brick_exists[hit_idx]=1. An effective hit clears the bit and adds POINTS_PER_BRICK to score; score saturates at 16'hFFFF.
    - Hits on a cleared brick, or with an out-of-range index, are acked with no other effect.
    - If an effective hit clears the last set bit, go to WON on that same edge.
    - Miss: ball_missed with lives>1 → lives decrements, respawn counter=0, go to RESPAWN. ball_missed with lives==1 → lives=0, go to LOST.
    - Hit and miss in the same cycle: the hit is applied first. If it clears the last brick, WON takes priority and the miss is ignored (lives unchanged). Otherwise the miss is processed as above, and the score and brick update from the hit is kept.
  - RESPAWN: ball_hold=1. The counter increments each frame. When counter==RESPAWN_FRAMES-1, go to SERVE. Hits are acked and ignored; misses are ignored.
  - WON: did_win_game=1. On start_rise: restart.
  - LOST: did_lose_game=1. On start_rise: restart.
  - Restart (from WON or LOST): bricks=all ones, lives=START_LIVES, score=0, go to SERVE. No ball_launch; a second start_rise is needed to serve.
- A held start key gives exactly one rising edge, so it never double-launches or launches straight after a restart.
- hit_ack is never asserted without hit_valid asserted in the previous cycle. hit_valid held high for N cycles is acked N times; each cycle is a separate event.
- Width rules:
  - hit_idx is compared unsigned against NUM_BRICKS.
  - The score adder is 17 bits wide; clamp to 16'hFFFF on carry.
  - lives never underflows below 0.

Decomposition:
- Shared package brick_game_pkg holds:
  - the typedef enum logic [2:0] game_state_t {SERVE, PLAY, RESPAWN, WON, LOST};
  - NUM_BRICKS_DEFAULT;
  - the brick colour constants already used by color_mapper.
- One sub-module, edge_detect_rise (reset value 1, as above), for start; it is reusable for other key inputs.
- The respawn counter stays inline.

Test Plan:
- Reset → release, start held at 1 → ball_launch never pulses. Release start, then press it → exactly one ball_launch pulse, state PLAY, ball_hold=0.
- In PLAY: hit_idx=3 → brick_exists=9'h1F7, score=10, hit_ack pulses once. Repeat hit_idx=3 → acked, score stays 10. hit_idx=12 → acked, no change.
- Clear all 9 bricks → score=90, did_win_game=1 on the edge of the 9th hit. start_rise → bricks=9'h1FF, score=0, lives=3, SERVE.
- Three ball_missed pulses, each followed by 60 frames and a start_rise → lives goes 2, 1, then 0 with did_lose_game=1. The RESPAWN dwell is exactly 60 frames.
- Last brick hit and ball_missed in the same cycle with lives=1 → did_win_game=1, lives stays 1.
- Assert Reset mid-PLAY with bricks 9'h0F0 and score 50 → outputs return immediately (asynchronously) to 9'h1FF, 0, lives 3, SERVE.
